y86_decode_slice: RTL and testbench



---
 rtl/y86_pkg.sv | 59 +++++
 rtl/y86_regfile.sv | 45 ++++
 rtl/y86_decode_slice.sv | 159 +++++++++++++++
 tb/tb_y86_decode_slice.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// =============================================================================
// y86_pkg : Y86-64 icode, register-ID, status constants and E-register layout
// Revision: 1.0
// =============================================================================
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RSP      = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         NUM_REGS = 15;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  S_AOK,
        pc:    64'd0,
        icode: I_NOP,
        ifun:  4'd0,
        valC:  64'd0,
        valA:  64'd0,
        valB:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// =============================================================================
// y86_regfile : 15x64 register file, two combinational reads, two writes
// Revision: 1.0
// =============================================================================
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] rdA_o,
    output logic [63:0] rdB_o,
    input  logic [3:0]  dstE_i,
    input  logic [63:0] valE_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valM_i
);

    logic [63:0] regs_q [NUM_REGS];

    // RNONE never equals a loop index, so writes to it fall through; M beats E.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst_n_i)
                regs_q[i] <= 64'd0;
            else if (dstM_i == 4'(i))
                regs_q[i] <= valM_i;
            else if (dstE_i == 4'(i))
                regs_q[i] <= valE_i;
        end
    end

    always_comb begin
        rdA_o = 64'd0;
        rdB_o = 64'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (srcA_i == 4'(i)) rdA_o = regs_q[i];
            if (srcB_i == 4'(i)) rdB_o = regs_q[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/y86_decode_slice.sv
`default_nettype none
// =============================================================================
// y86_decode_slice : F predicted-PC register, decode/forwarding, D->E register
// Revision: 1.0
// =============================================================================
module y86_decode_slice
    import y86_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        F_stall_i,
    input  logic        F_bubble_i,
    input  logic [63:0] f_predPC_i,
    output logic [63:0] F_predPC_o,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  D_ifun_i,
    input  logic [3:0]  D_rA_i,
    input  logic [3:0]  D_rB_i,
    input  logic [63:0] D_valC_i,
    input  logic [63:0] D_valP_i,
    input  logic [63:0] D_pc_i,
    input  logic [2:0]  D_stat_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [63:0] e_valE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [63:0] m_valM_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [63:0] M_valE_i,
    input  logic [3:0]  W_dstM_i,
    input  logic [63:0] W_valM_i,
    input  logic [3:0]  W_dstE_i,
    input  logic [63:0] W_valE_i,
    input  logic        E_stall_i,
    input  logic        E_bubble_i,
    output logic [63:0] d_valA_o,
    output logic [63:0] d_valB_o,
    output logic [3:0]  d_srcA_o,
    output logic [3:0]  d_srcB_o,
    output logic [3:0]  d_dstE_o,
    output logic [3:0]  d_dstM_o,
    output logic [2:0]  d_stat_o,
    output logic [2:0]  E_stat_o,
    output logic [63:0] E_pc_o,
    output logic [3:0]  E_icode_o,
    output logic [3:0]  E_ifun_o,
    output logic [63:0] E_valA_o,
    output logic [63:0] E_valB_o,
    output logic [63:0] E_valC_o,
    output logic [3:0]  E_dstE_o,
    output logic [3:0]  E_dstM_o,
    output logic [3:0]  E_srcA_o,
    output logic [3:0]  E_srcB_o
);

    logic [63:0] predpc_q;
    e_reg_t      e_q;
    e_reg_t      e_d;
    logic [63:0] rf_rdA;
    logic [63:0] rf_rdB;

    always_comb begin
        case (D_icode_i)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA_o = D_rA_i;
            I_POPQ, I_RET:                      d_srcA_o = RSP;
            default:                            d_srcA_o = RNONE;
        endcase
        case (D_icode_i)
            I_OPQ, I_RMMOVQ, I_MRMOVQ:          d_srcB_o = D_rB_i;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_srcB_o = RSP;
            default:                            d_srcB_o = RNONE;
        endcase
        case (D_icode_i)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE_o = D_rB_i;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_dstE_o = RSP;
            default:                            d_dstE_o = RNONE;
        endcase
        case (D_icode_i)
            I_MRMOVQ, I_POPQ:                   d_dstM_o = D_rA_i;
            default:                            d_dstM_o = RNONE;
        endcase
    end

    y86_regfile u_regfile (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .srcA_i  (d_srcA_o),
        .srcB_i  (d_srcB_o),
        .rdA_o   (rf_rdA),
        .rdB_o   (rf_rdB),
        .dstE_i  (W_dstE_i),
        .valE_i  (W_valE_i),
        .dstM_i  (W_dstM_i),
        .valM_i  (W_valM_i)
    );

    // Youngest producer wins; an RNONE source never matches and reads 0.
    always_comb begin
        if (D_icode_i == I_CALL || D_icode_i == I_JXX) d_valA_o = D_valP_i;
        else if (d_srcA_o == RNONE)                    d_valA_o = 64'd0;
        else if (d_srcA_o == e_dstE_i)                 d_valA_o = e_valE_i;
        else if (d_srcA_o == M_dstM_i)                 d_valA_o = m_valM_i;
        else if (d_srcA_o == M_dstE_i)                 d_valA_o = M_valE_i;
        else if (d_srcA_o == W_dstM_i)                 d_valA_o = W_valM_i;
        else if (d_srcA_o == W_dstE_i)                 d_valA_o = W_valE_i;
        else                                           d_valA_o = rf_rdA;

        if (d_srcB_o == RNONE)                         d_valB_o = 64'd0;
        else if (d_srcB_o == e_dstE_i)                 d_valB_o = e_valE_i;
        else if (d_srcB_o == M_dstM_i)                 d_valB_o = m_valM_i;
        else if (d_srcB_o == M_dstE_i)                 d_valB_o = M_valE_i;
        else if (d_srcB_o == W_dstM_i)                 d_valB_o = W_valM_i;
        else if (d_srcB_o == W_dstE_i)                 d_valB_o = W_valE_i;
        else                                           d_valB_o = rf_rdB;
    end

    assign d_stat_o = D_stat_i;

    always_comb begin
        e_d       = E_BUBBLE;
        e_d.stat  = d_stat_o;
        e_d.pc    = D_pc_i;
        e_d.icode = D_icode_i;
        e_d.ifun  = D_ifun_i;
        e_d.valC  = D_valC_i;
        e_d.valA  = d_valA_o;
        e_d.valB  = d_valB_o;
        e_d.dstE  = d_dstE_o;
        e_d.dstM  = d_dstM_o;
        e_d.srcA  = d_srcA_o;
        e_d.srcB  = d_srcB_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)        predpc_q <= 64'd0;
        else if (F_bubble_i) predpc_q <= 64'd0;
        else if (!F_stall_i) predpc_q <= f_predPC_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)        e_q <= E_BUBBLE;
        else if (E_bubble_i) e_q <= E_BUBBLE;
        else if (!E_stall_i) e_q <= e_d;
    end

    assign F_predPC_o = predpc_q;
    assign E_stat_o   = e_q.stat;
    assign E_pc_o     = e_q.pc;
    assign E_icode_o  = e_q.icode;
    assign E_ifun_o   = e_q.ifun;
    assign E_valA_o   = e_q.valA;
    assign E_valB_o   = e_q.valB;
    assign E_valC_o   = e_q.valC;
    assign E_dstE_o   = e_q.dstE;
    assign E_dstM_o   = e_q.dstM;
    assign E_srcA_o   = e_q.srcA;
    assign E_srcB_o   = e_q.srcB;

endmodule
`default_nettype wire

// File: tb/tb_y86_decode_slice.sv
`default_nettype none
// =============================================================================
// tb_y86_decode_slice : directed and randomized checks against a reference model
// Revision: 1.0
// =============================================================================
module tb_y86_decode_slice;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_stall, F_bubble, E_stall, E_bubble;
    logic [63:0] f_predPC, F_predPC;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP, D_pc;
    logic [2:0]  D_stat;
    logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic [63:0] d_valA, d_valB;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [2:0]  d_stat;
    logic [2:0]  E_stat;
    logic [63:0] E_pc, E_valA, E_valB, E_valC;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;

    int checks = 0;
    int errors = 0;

    logic [63:0] mreg [15];

    localparam int EW = 283;
    localparam logic [EW-1:0] E_RESET = {3'd1, 64'd0, 4'h1, 4'h0, 192'd0, 16'hFFFF};

    always #5 clk = ~clk;

    y86_decode_slice dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .F_stall_i(F_stall), .F_bubble_i(F_bubble),
        .f_predPC_i(f_predPC), .F_predPC_o(F_predPC),
        .D_icode_i(D_icode), .D_ifun_i(D_ifun), .D_rA_i(D_rA), .D_rB_i(D_rB),
        .D_valC_i(D_valC), .D_valP_i(D_valP), .D_pc_i(D_pc), .D_stat_i(D_stat),
        .e_dstE_i(e_dstE), .e_valE_i(e_valE),
        .M_dstM_i(M_dstM), .m_valM_i(m_valM),
        .M_dstE_i(M_dstE), .M_valE_i(M_valE),
        .W_dstM_i(W_dstM), .W_valM_i(W_valM),
        .W_dstE_i(W_dstE), .W_valE_i(W_valE),
        .E_stall_i(E_stall), .E_bubble_i(E_bubble),
        .d_valA_o(d_valA), .d_valB_o(d_valB),
        .d_srcA_o(d_srcA), .d_srcB_o(d_srcB), .d_dstE_o(d_dstE), .d_dstM_o(d_dstM),
        .d_stat_o(d_stat),
        .E_stat_o(E_stat), .E_pc_o(E_pc), .E_icode_o(E_icode), .E_ifun_o(E_ifun),
        .E_valA_o(E_valA), .E_valB_o(E_valB), .E_valC_o(E_valC),
        .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB)
    );

    function automatic logic [3:0] ref_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'hB, 4'h9})             return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h6, 4'h4, 4'h5})       return rb;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6})       return rb;
        if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] ref_operand(input logic [3:0] src);
        if (src == 4'hF)   return 64'd0;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return mreg[src];
    endfunction

    function automatic logic [63:0] ref_valA();
        if (D_icode == 4'h8 || D_icode == 4'h7) return D_valP;
        return ref_operand(ref_srcA(D_icode, D_rA));
    endfunction

    task automatic idle();
        F_stall = 0; F_bubble = 0; E_stall = 0; E_bubble = 0;
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = 0; m_valM = 0; M_valE = 0; W_valM = 0; W_valE = 0;
        D_icode = 4'h1; D_ifun = 0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 0; D_valP = 0; D_pc = 0; D_stat = 3'd1;
    endtask

    // Reference register file follows every edge so directed and random phases agree.
    task automatic tick();
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
        end else begin
            if (W_dstE != 4'hF) mreg[W_dstE] = W_valE;
            if (W_dstM != 4'hF) mreg[W_dstM] = W_valM;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        f_predPC = 64'hDEAD_BEEF;
        W_dstE = 4'h3; W_valE = 64'h77;
        tick();
        checks++; if (F_predPC !== 64'd0) begin errors++; $display("FAIL reset_predpc got %h want 0", F_predPC); end
        checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h want 1", E_icode); end
        checks++; if (E_stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %h want 1", E_stat); end
        checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE got %h want F", E_dstE); end
        rst_n = 1;
        idle();
        D_icode = 4'h6;
        for (int r = 0; r < 15; r++) begin
            D_rA = 4'(r);
            #1;
            checks++;
            if (d_valA !== 64'd0) begin errors++; $display("FAIL reset_regread r%0d got %h want 0", r, d_valA); end
        end
    endtask

    task automatic test_regfile_read();
        idle();
        W_dstE = 4'h3; W_valE = 64'd5;
        tick();
        idle();
        D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'hF;
        #1;
        checks++; if (d_valA !== 64'd5) begin errors++; $display("FAIL rf_read valA got %h want 5", d_valA); end
        checks++; if (d_srcA !== 4'h3) begin errors++; $display("FAIL rf_read srcA got %h want 3", d_srcA); end
        checks++; if (d_dstE !== 4'hF) begin errors++; $display("FAIL rf_read dstE got %h want F", d_dstE); end
    endtask

    task automatic test_forward_priority();
        idle();
        D_icode = 4'h6; D_rA = 4'h2;
        e_dstE = 4'h2; e_valE = 64'd11;
        M_dstM = 4'h2; m_valM = 64'd22;
        W_dstE = 4'h2; W_valE = 64'd33;
        #1;
        checks++; if (d_valA !== 64'd11) begin errors++; $display("FAIL fwd_e got %0d want 11", d_valA); end
        e_dstE = 4'hF;
        #1;
        checks++; if (d_valA !== 64'd22) begin errors++; $display("FAIL fwd_m got %0d want 22", d_valA); end
        M_dstM = 4'hF;
        #1;
        checks++; if (d_valA !== 64'd33) begin errors++; $display("FAIL fwd_w got %0d want 33", d_valA); end
        idle();
    endtask

    task automatic test_call();
        idle();
        D_icode = 4'h8; D_valP = 64'h100; D_rA = 4'h2;
        e_dstE = 4'h2; e_valE = 64'd99;
        #1;
        checks++; if (d_valA !== 64'h100) begin errors++; $display("FAIL call_valA got %h want 100", d_valA); end
        checks++; if (d_srcB !== 4'h4) begin errors++; $display("FAIL call_srcB got %h want 4", d_srcB); end
        checks++; if (d_dstE !== 4'h4) begin errors++; $display("FAIL call_dstE got %h want 4", d_dstE); end
        idle();
    endtask

    task automatic test_same_reg_write();
        idle();
        W_dstE = 4'h4; W_valE = 64'd7;
        W_dstM = 4'h4; W_valM = 64'd9;
        tick();
        idle();
        D_icode = 4'hB; D_rA = 4'h1;
        #1;
        checks++; if (d_valA !== 64'd9) begin errors++; $display("FAIL same_reg rsp got %0d want 9", d_valA); end
        checks++; if (d_srcA !== 4'h4) begin errors++; $display("FAIL pop_srcA got %h want 4", d_srcA); end
        checks++; if (d_dstM !== 4'h1) begin errors++; $display("FAIL pop_dstM got %h want 1", d_dstM); end
    endtask

    task automatic test_stall_bubble();
        idle();
        f_predPC = 64'd10;
        tick();
        checks++; if (F_predPC !== 64'd10) begin errors++; $display("FAIL f_load got %0d want 10", F_predPC); end
        F_stall = 1; f_predPC = 64'd20;
        tick();
        checks++; if (F_predPC !== 64'd10) begin errors++; $display("FAIL f_stall got %0d want 10", F_predPC); end
        F_bubble = 1;
        tick();
        checks++; if (F_predPC !== 64'd0) begin errors++; $display("FAIL f_bubble got %0d want 0", F_predPC); end
        idle();
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        tick();
        checks++; if (E_icode !== 4'h6) begin errors++; $display("FAIL e_load got %h want 6", E_icode); end
        E_stall = 1; D_icode = 4'h3;
        tick();
        checks++; if (E_icode !== 4'h6) begin errors++; $display("FAIL e_stall got %h want 6", E_icode); end
        E_bubble = 1;
        tick();
        checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL e_bubble icode got %h want 1", E_icode); end
        checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL e_bubble dstE got %h want F", E_dstE); end
        idle();
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        logic [EW-1:0] exp_e;
        logic [EW-1:0] got_e;
        logic [63:0]   exp_f;
        logic [63:0]   exp_a, exp_b;
        logic [3:0]    exp_sa, exp_sb, exp_de, exp_dm;
        exp_e = {E_stat, E_pc, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
        exp_f = F_predPC;
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            F_stall  = ($urandom_range(0, 4) == 0);
            F_bubble = ($urandom_range(0, 7) == 0);
            E_stall  = ($urandom_range(0, 4) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            f_predPC = {$urandom, $urandom};
            D_icode  = 4'($urandom_range(0, 11));
            D_ifun   = 4'($urandom);
            D_rA     = rand_reg();
            D_rB     = rand_reg();
            D_valC   = {$urandom, $urandom};
            D_valP   = {$urandom, $urandom};
            D_pc     = {$urandom, $urandom};
            D_stat   = 3'($urandom_range(1, 4));
            e_dstE = rand_reg(); e_valE = {$urandom, $urandom};
            M_dstM = rand_reg(); m_valM = {$urandom, $urandom};
            M_dstE = rand_reg(); M_valE = {$urandom, $urandom};
            W_dstM = rand_reg(); W_valM = {$urandom, $urandom};
            W_dstE = rand_reg(); W_valE = {$urandom, $urandom};
            #1;
            exp_sa = ref_srcA(D_icode, D_rA);
            exp_sb = ref_srcB(D_icode, D_rB);
            exp_de = ref_dstE(D_icode, D_rB);
            exp_dm = ref_dstM(D_icode, D_rA);
            exp_a  = ref_valA();
            exp_b  = ref_operand(exp_sb);
            checks++;
            if ({d_srcA, d_srcB, d_dstE, d_dstM, d_stat} !== {exp_sa, exp_sb, exp_de, exp_dm, D_stat}) begin
                errors++;
                $display("FAIL rand_ids n%0d got %h want %h", n,
                         {d_srcA, d_srcB, d_dstE, d_dstM, d_stat}, {exp_sa, exp_sb, exp_de, exp_dm, D_stat});
            end
            checks++;
            if ({d_valA, d_valB} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL rand_vals n%0d icode %h got %h %h want %h %h", n, D_icode, d_valA, d_valB, exp_a, exp_b);
            end
            if (!rst_n || E_bubble) exp_e = E_RESET;
            else if (!E_stall)      exp_e = {D_stat, D_pc, D_icode, D_ifun, D_valC, exp_a, exp_b,
                                             exp_de, exp_dm, exp_sa, exp_sb};
            if (!rst_n || F_bubble) exp_f = 64'd0;
            else if (!F_stall)      exp_f = f_predPC;
            tick();
            got_e = {E_stat, E_pc, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL rand_ereg n%0d got %h want %h", n, got_e, exp_e);
            end
            checks++;
            if (F_predPC !== exp_f) begin
                errors++;
                $display("FAIL rand_freg n%0d got %h want %h", n, F_predPC, exp_f);
            end
        end
    endtask

    initial begin
        rst_n = 0;
        f_predPC = 0;
        idle();
        test_reset();
        test_regfile_read();
        test_forward_priority();
        test_call();
        test_same_reg_write();
        test_stall_bubble();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
